// File: rtl/csplit_nway_sync.sv
// N-way fork: every accepted input word (whole, or as an MSB-first slice) is queued into a
// per-channel FIFO. Optional macro CSPLIT_MASK_EN adds the per-word channel enable i_mask.
module csplit_nway_sync #(
    parameter int DATA_WIDTHI = 32,
    parameter int N_OUT       = 5,
    parameter int MODE        = 1,
    parameter int DEPTH       = 2,
    localparam int OUT_W      = (MODE != 0) ? DATA_WIDTHI / N_OUT : DATA_WIDTHI
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_drive,
    output logic                     o_free,
    input  logic [DATA_WIDTHI-1:0]   i_data,
    output logic [N_OUT-1:0]         o_driveNext,
    input  logic [N_OUT-1:0]         i_freeNext,
`ifdef CSPLIT_MASK_EN
    input  logic [N_OUT-1:0]         i_mask,
`endif
    output logic [N_OUT*OUT_W-1:0]   o_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    generate
        if ((MODE != 0 && (DATA_WIDTHI % N_OUT) != 0) || N_OUT < 2 || N_OUT > 16 ||
            DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_config
            $error("csplit_nway_sync: illegal parameter combination");
        end
    endgenerate

    logic             run_reg;
    logic [N_OUT-1:0] enable;
    logic [N_OUT-1:0] room;
    logic             accept;

`ifdef CSPLIT_MASK_EN
    assign enable = i_mask;
`else
    assign enable = '1;
`endif

    // run_reg holds o_free low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // Disabled channels never block; all-zero enable therefore accepts and drops the word.
    assign o_free = run_reg & (&room);
    assign accept = i_drive & o_free;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_chan
            logic [OUT_W-1:0] mem_reg [DEPTH];
            logic [PTR_W-1:0] head_reg;
            logic [PTR_W-1:0] tail_reg;
            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;
            logic [OUT_W-1:0] slice;
            logic             push;
            logic             pop;

            if (MODE != 0) begin : g_split
                assign slice = i_data[DATA_WIDTHI-1-gi*OUT_W -: OUT_W];
            end else begin : g_copy
                assign slice = i_data;
            end

            assign push = accept & enable[gi];
            assign pop  = (count_reg != '0) & i_freeNext[gi];
            assign room[gi] = ~enable[gi] | (count_reg < CNT_W'(DEPTH));

            always_comb begin
                count_next = count_reg;
                if (push && !pop) begin
                    count_next = count_reg + 1'b1;
                end else if (pop && !push) begin
                    count_next = count_reg - 1'b1;
                end
            end

            // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                    if (push) begin
                        tail_reg <= tail_reg + 1'b1;
                    end
                    if (pop) begin
                        head_reg <= head_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_reg[tail_reg] <= slice;
                end
            end

            assign o_driveNext[gi]              = (count_reg != '0);
            assign o_data[gi*OUT_W +: OUT_W]    = mem_reg[head_reg];
        end
    endgenerate

endmodule

// File: tb/tb_csplit_nway_sync.sv
// Bench for csplit_nway_sync: directed scenarios on a 40-bit split fork and a 32-bit copy
// fork, then a randomized run of the split fork against a per-channel queue model.
module tb_csplit_nway_sync;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         a_drive, a_free;
    logic [39:0]  a_data;
    logic [4:0]   a_valid, a_ready, a_mask;
    logic [39:0]  a_out;

    logic         b_drive, b_free;
    logic [31:0]  b_data;
    logic [4:0]   b_valid, b_ready, b_mask;
    logic [159:0] b_out;

    int checks = 0;
    int failures = 0;

    csplit_nway_sync #(.DATA_WIDTHI(40), .N_OUT(5), .MODE(1), .DEPTH(2)) u_split (
        .clk(clk), .rstn(rstn), .i_drive(a_drive), .o_free(a_free), .i_data(a_data),
        .o_driveNext(a_valid), .i_freeNext(a_ready),
`ifdef CSPLIT_MASK_EN
        .i_mask(a_mask),
`endif
        .o_data(a_out)
    );

    csplit_nway_sync #(.DATA_WIDTHI(32), .N_OUT(5), .MODE(0), .DEPTH(4)) u_copy (
        .clk(clk), .rstn(rstn), .i_drive(b_drive), .o_free(b_free), .i_data(b_data),
        .o_driveNext(b_valid), .i_freeNext(b_ready),
`ifdef CSPLIT_MASK_EN
        .i_mask(b_mask),
`endif
        .o_data(b_out)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Channel k of the split fork takes byte k counted from the MSB end.
    function automatic logic [7:0] sl(input logic [39:0] w, input int k);
        return 8'(w >> (8 * (4 - k)));
    endfunction

    task automatic chk_a_word(input string tag, input logic [39:0] w);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_ch%0d", tag, k), 64'(a_out[8*k +: 8]), 64'(sl(w, k)));
        end
    endtask

    logic [39:0] w [4];
    logic [39:0] wn;
    logic [31:0] bq [$];
    logic [39:0] mq [5][$];

    initial begin
        a_drive = 1'b0; a_data = '0; a_ready = '1; a_mask = '1;
        b_drive = 1'b0; b_data = '0; b_ready = '1; b_mask = '1;

        // Reset state and release
        repeat (2) @(negedge clk);
        chk("rst_a_free", 64'(a_free), 64'd0);
        chk("rst_a_valid", 64'(a_valid), 64'd0);
        chk("rst_b_free", 64'(b_free), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_a_free", 64'(a_free), 64'd1);
        chk("rel_b_free", 64'(b_free), 64'd1);

        // Split latency
        a_data = 40'hAA_BB_CC_DD_EE; a_drive = 1'b1;
        @(negedge clk);
        a_drive = 1'b0;
        chk("t1_valid", 64'(a_valid), 64'h1F);
        chk("t1_ch0", 64'(a_out[7:0]), 64'hAA);
        chk("t1_ch4", 64'(a_out[39:32]), 64'hEE);
        chk_a_word("t1", 40'hAA_BB_CC_DD_EE);
        @(negedge clk);
        chk("t1_drain", 64'(a_valid), 64'd0);

        // Copy mode
        b_data = 32'h1234_5678; b_drive = 1'b1;
        @(negedge clk);
        b_drive = 1'b0;
        chk("t2_valid", 64'(b_valid), 64'h1F);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t2_ch%0d", k), 64'(b_out[32*k +: 32]), 64'h1234_5678);
        @(negedge clk);
        chk("t2_drain", 64'(b_valid), 64'd0);

        // Backpressure on channel 2
        for (int i = 0; i < 4; i++) w[i] = {8'($urandom), $urandom};
        a_ready = 5'b11011; a_drive = 1'b1; a_data = w[0];
        @(negedge clk);
        chk("t3_free1", 64'(a_free), 64'd1); a_data = w[1];
        @(negedge clk);
        chk("t3_full", 64'(a_free), 64'd0); a_data = w[2];
        @(negedge clk);
        chk("t3_stall_free", 64'(a_free), 64'd0);
        chk("t3_stall_valid", 64'(a_valid), 64'b00100);
        chk("t3_ch2_w0", 64'(a_out[23:16]), 64'(sl(w[0], 2)));
        a_ready = '1;
        @(negedge clk);
        chk("t3_refree", 64'(a_free), 64'd1);
        chk("t3_valid_w1", 64'(a_valid), 64'b00100);
        chk("t3_ch2_w1", 64'(a_out[23:16]), 64'(sl(w[1], 2)));
        @(negedge clk);
        chk("t3_valid_w2", 64'(a_valid), 64'h1F);
        chk_a_word("t3_w2", w[2]); a_data = w[3];
        @(negedge clk);
        chk("t3_valid_w3", 64'(a_valid), 64'h1F);
        chk_a_word("t3_w3", w[3]); a_drive = 1'b0;
        @(negedge clk);
        chk("t3_empty", 64'(a_valid), 64'd0);

        // Wrap with simultaneous push/pop on the copy fork
        b_ready = 5'b11110; b_data = $urandom; bq.push_back(b_data); b_drive = 1'b1;
        @(negedge clk);
        b_ready = '1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_head", 64'(b_out[31:0]), 64'(bq[0]));
            chk("t4_valid", 64'(b_valid), 64'h1F);
            chk("t4_free", 64'(b_free), 64'd1);
            b_data = $urandom; bq.push_back(b_data);
            $display("txn wrap %0d word=%h", i, b_data);
            @(negedge clk);
            void'(bq.pop_front());
        end
        chk("t4_last", 64'(b_out[31:0]), 64'(bq[0]));
        b_drive = 1'b0;
        @(negedge clk);
        chk("t4_empty", 64'(b_valid), 64'd0);

        // Asynchronous reset mid-operation
        a_ready = 5'b10111; a_drive = 1'b1; a_data = w[0];
        @(negedge clk);
        a_data = w[1];
        @(negedge clk);
        a_drive = 1'b0;
        chk("t5_pre_ch3", 64'(a_valid[3]), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(a_valid), 64'd0);
        chk("t5_rst_free", 64'(a_free), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("t5_free", 64'(a_free), 64'd1);
        wn = {8'($urandom), $urandom};
        a_ready = '1; a_drive = 1'b1; a_data = wn;
        @(negedge clk);
        a_drive = 1'b0;
        chk("t5_valid", 64'(a_valid), 64'h1F);
        chk_a_word("t5_new", wn);
        @(negedge clk);
        chk("t5_empty", 64'(a_valid), 64'd0);

`ifdef CSPLIT_MASK_EN
        // Masked channels neither receive nor gate o_free
        a_ready = 5'b11101; a_drive = 1'b1; a_data = w[0];
        @(negedge clk);
        a_data = w[1];
        @(negedge clk);
        chk("t6_full", 64'(a_free), 64'd0);
        a_mask = 5'b10101; a_data = w[2];
        #1;
        chk("t6_masked_free", 64'(a_free), 64'd1);
        @(negedge clk);
        chk("t6_valid", 64'(a_valid), 64'b10111);
        chk("t6_ch1", 64'(a_out[15:8]), 64'(sl(w[0], 1)));
        chk("t6_ch0", 64'(a_out[7:0]), 64'(sl(w[2], 0)));
        chk("t6_ch4", 64'(a_out[39:32]), 64'(sl(w[2], 4)));
        a_mask = 5'b00000; a_data = w[3];
        #1;
        chk("t6_zero_free", 64'(a_free), 64'd1);
        @(negedge clk);
        chk("t6_dropped", 64'(a_valid), 64'b00010);
        a_drive = 1'b0; a_mask = '1; a_ready = '1;
        repeat (2) @(negedge clk);
        chk("t6_empty", 64'(a_valid), 64'd0);
`endif

        // Randomized run against the queue model
        a_drive = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rnd_rst_valid", 64'(a_valid), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic [4:0] exp_valid;
            logic       exp_free;
            logic       acc;
            for (int k = 0; k < 5; k++) begin
                exp_valid[k] = (mq[k].size() != 0);
                if (mq[k].size() != 0)
                    chk($sformatf("rnd_data_ch%0d", k), 64'(a_out[8*k +: 8]), 64'(sl(mq[k][0], k)));
            end
            chk("rnd_valid", 64'(a_valid), 64'(exp_valid));
            a_drive = ($urandom_range(0, 3) != 0);
            a_data  = {8'($urandom), $urandom};
            a_ready = 5'($urandom);
`ifdef CSPLIT_MASK_EN
            a_mask  = 5'($urandom);
`endif
            #1;
            exp_free = 1'b1;
            for (int k = 0; k < 5; k++)
                if (a_mask[k] && mq[k].size() >= 2) exp_free = 1'b0;
            chk("rnd_free", 64'(a_free), 64'(exp_free));
            acc = a_drive & exp_free;
            for (int k = 0; k < 5; k++) begin
                if (mq[k].size() != 0 && a_ready[k]) void'(mq[k].pop_front());
                if (acc && a_mask[k]) mq[k].push_back(a_data);
            end
            if (acc) $display("txn rnd %0d word=%h mask=%b", cyc, a_data, a_mask);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
